// File: rtl/bpred.sv
// Direct-mapped BTB with 2-bit saturating direction counters and zero-latency lookup.
// Optional macro BPRED_BYPASS_EN forwards a same-cycle update of the looked-up entry to the outputs.
module bpred #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned INDEX_W = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] pred_pc,
  input  logic [31:0] update_neip,
  input  logic [31:0] update_target,
  input  logic        update_taken,
  input  logic        update_mispred,
  input  logic        update_valid,
  output logic [31:0] pred_target_curr,
  output logic        pred_taken_curr,
  output logic        pred_hit_curr
);

  localparam int unsigned TAG_W = 32 - INDEX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] pidx, uidx;
  logic [TAG_W-1:0]   ptag, utag;
  logic               u_hit;
  logic [31:0]        nxt_tgt;
  logic [1:0]         nxt_ctr;
  logic               l_hit;
  logic [31:0]        l_tgt;
  logic [1:0]         l_ctr;
  logic               unused_addr_lsbs;

  assign pidx  = pred_pc[INDEX_W+1:2];
  assign ptag  = pred_pc[31:INDEX_W+2];
  assign uidx  = update_neip[INDEX_W+1:2];
  assign utag  = update_neip[31:INDEX_W+2];
  assign u_hit = valid_q[uidx] && (tag_q[uidx] == utag);
  assign unused_addr_lsbs = ^{pred_pc[1:0], update_neip[1:0]};

  // Post-update contents of the entry addressed by update_neip
  always_comb begin
    nxt_tgt = target_q[uidx];
    nxt_ctr = ctr_q[uidx];
    if (!u_hit) begin
      nxt_tgt = update_target;
      nxt_ctr = update_taken ? 2'b10 : 2'b01;
    end else begin
      if (update_taken) nxt_tgt = update_target;
      if (update_mispred) begin
        nxt_ctr = update_taken ? 2'b11 : 2'b00;
      end else if (update_taken && (ctr_q[uidx] != 2'b11)) begin
        nxt_ctr = ctr_q[uidx] + 2'b01;
      end else if (!update_taken && (ctr_q[uidx] != 2'b00)) begin
        nxt_ctr = ctr_q[uidx] - 2'b01;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      valid_q  <= '0;
      target_q <= '{default: 32'h0};
      ctr_q    <= '{default: 2'b01};
    end else if (update_valid) begin
      valid_q[uidx]  <= 1'b1;
      tag_q[uidx]    <= utag;
      target_q[uidx] <= nxt_tgt;
      ctr_q[uidx]    <= nxt_ctr;
    end
  end

  // Combinational lookup, optionally overridden by the in-flight update
  always_comb begin
    l_hit = valid_q[pidx] && (tag_q[pidx] == ptag);
    l_tgt = target_q[pidx];
    l_ctr = ctr_q[pidx];
`ifdef BPRED_BYPASS_EN
    if (update_valid && !reset && (pidx == uidx) && (ptag == utag)) begin
      l_hit = 1'b1;
      l_tgt = nxt_tgt;
      l_ctr = nxt_ctr;
    end
`endif
  end

  assign pred_hit_curr    = l_hit;
  assign pred_taken_curr  = l_hit & l_ctr[1];
  assign pred_target_curr = l_hit ? l_tgt : 32'h0;

endmodule

// File: tb/tb_bpred.sv
// Directed scoreboard bench for bpred: expectations queued per lookup, compared with immediate assertions.
module tb_bpred;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] pred_pc;
  logic [31:0] update_neip;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_mispred;
  logic        update_valid;
  logic [31:0] pred_target_curr;
  logic        pred_taken_curr;
  logic        pred_hit_curr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];

  bpred #(.ENTRIES(16), .INDEX_W(4)) dut (
    .CLK              (CLK),
    .reset            (reset),
    .pred_pc          (pred_pc),
    .update_neip      (update_neip),
    .update_target    (update_target),
    .update_taken     (update_taken),
    .update_mispred   (update_mispred),
    .update_valid     (update_valid),
    .pred_target_curr (pred_target_curr),
    .pred_taken_curr  (pred_taken_curr),
    .pred_hit_curr    (pred_hit_curr)
  );

  always #5 CLK = ~CLK;

  // Pop the oldest expectation and compare it against the current outputs
  task automatic compare();
    exp_t e;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >0");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      assert (pred_hit_curr === e.hit) else begin
        n_fail++;
        $error("FAIL %s hit: observed %0b expected %0b", e.name, pred_hit_curr, e.hit);
      end
      n_tests++;
      assert (pred_taken_curr === e.taken) else begin
        n_fail++;
        $error("FAIL %s taken: observed %0b expected %0b", e.name, pred_taken_curr, e.taken);
      end
      n_tests++;
      assert (pred_target_curr === e.tgt) else begin
        n_fail++;
        $error("FAIL %s target: observed %0d expected %0d", e.name, pred_target_curr, e.tgt);
      end
    end
  endtask

  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic hit, input logic taken, input logic [31:0] tgt);
    exp_t e;
    e.name = name; e.hit = hit; e.taken = taken; e.tgt = tgt;
    pred_pc = pc;
    sb.push_back(e);
    #2;
    compare();
    #1;
  endtask

  task automatic upd(input logic [31:0] neip, input logic [31:0] tgt,
                     input logic taken, input logic mispred);
    update_neip    = neip;
    update_target  = tgt;
    update_taken   = taken;
    update_mispred = mispred;
    update_valid   = 1'b1;
    @(posedge CLK);
    #1;
    update_valid   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; pred_pc = '0; update_neip = '0; update_target = '0;
    update_taken = 1'b0; update_mispred = 1'b0; update_valid = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;

    lookup("reset_miss", 32'd16, 1'b0, 1'b0, 32'd0);

    // Allocation ignores mispred: taken allocates counter 10
    upd(32'd16, 32'd45, 1'b1, 1'b1);
    lookup("alloc16", 32'd16, 1'b1, 1'b1, 32'd45);
    upd(32'd64, 32'd25, 1'b0, 1'b1);
    lookup("alloc64", 32'd64, 1'b1, 1'b0, 32'd25);
    lookup("keep16", 32'd16, 1'b1, 1'b1, 32'd45);

    // Counter saturation and hysteresis
    do_reset();
    lookup("reset2_miss", 32'd16, 1'b0, 1'b0, 32'd0);
    upd(32'd16, 32'd45, 1'b1, 1'b0);
    upd(32'd16, 32'd45, 1'b1, 1'b0);
    upd(32'd16, 32'd45, 1'b1, 1'b0);
    upd(32'd16, 32'd77, 1'b0, 1'b0);
    lookup("ctr_11_dec", 32'd16, 1'b1, 1'b1, 32'd45);
    upd(32'd16, 32'd77, 1'b0, 1'b0);
    lookup("ctr_01", 32'd16, 1'b1, 1'b0, 32'd45);
    upd(32'd16, 32'd77, 1'b0, 1'b0);
    upd(32'd16, 32'd77, 1'b0, 1'b0);
    lookup("ctr_sat00", 32'd16, 1'b1, 1'b0, 32'd45);
    upd(32'd16, 32'd60, 1'b1, 1'b1);
    upd(32'd16, 32'd61, 1'b0, 1'b0);
    lookup("mispred_t_then_dec", 32'd16, 1'b1, 1'b1, 32'd60);
    upd(32'd16, 32'd62, 1'b0, 1'b1);
    lookup("mispred_nt", 32'd16, 1'b1, 1'b0, 32'd60);
    upd(32'd16, 32'd50, 1'b1, 1'b0);
    lookup("inc_00_01_tgt", 32'd16, 1'b1, 1'b0, 32'd50);

    // Conflict on index 4 with a different tag
    upd(32'd80, 32'd99, 1'b1, 1'b0);
    lookup("evicted16", 32'd16, 1'b0, 1'b0, 32'd0);
    lookup("alloc80", 32'd80, 1'b1, 1'b1, 32'd99);
    lookup("lsb_ignored", 32'd83, 1'b1, 1'b1, 32'd99);

    // update_valid low leaves state untouched
    update_neip = 32'd80; update_target = 32'd1; update_taken = 1'b0;
    update_mispred = 1'b1; update_valid = 1'b0;
    @(posedge CLK); #1;
    lookup("no_valid", 32'd80, 1'b1, 1'b1, 32'd99);

    // Reset with a concurrent update discards everything
    reset = 1'b1;
    update_neip = 32'd16; update_target = 32'd33; update_taken = 1'b1;
    update_mispred = 1'b0; update_valid = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0; update_valid = 1'b0;
    lookup("midreset80", 32'd80, 1'b0, 1'b0, 32'd0);
    lookup("midreset16", 32'd16, 1'b0, 1'b0, 32'd0);

    // Same-cycle update and lookup of the same entry
    pred_pc = 32'd16;
    update_neip = 32'd16; update_target = 32'd45; update_taken = 1'b1;
    update_mispred = 1'b0; update_valid = 1'b1;
    e.name = "same_cycle";
`ifdef BPRED_BYPASS_EN
    e.hit = 1'b1; e.taken = 1'b1; e.tgt = 32'd45;
`else
    e.hit = 1'b0; e.taken = 1'b0; e.tgt = 32'd0;
`endif
    sb.push_back(e);
    #2;
    compare();
    @(posedge CLK); #1;
    update_valid = 1'b0;
    lookup("after_same_cycle", 32'd16, 1'b1, 1'b1, 32'd45);

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bpred.md
BPRED -- requirements
Module: bpred

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped BTB entries (power of two).
REQ-002 Parameter INDEX_W, default 4, log2(ENTRIES).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pred_pc  input  32  lookup address.
REQ-006 update_neip  input  32  address of the resolved branch being trained.
REQ-007 update_target  input  32  resolved branch target.
REQ-008 update_taken  input  1  resolved direction, 1 = taken.
REQ-009 update_mispred  input  1  resolved branch was mispredicted.
REQ-010 update_valid  input  1  qualifies all update_* inputs.
REQ-011 pred_target_curr  output  32  predicted target for pred_pc.
REQ-012 pred_taken_curr  output  1  predicted direction for pred_pc.
REQ-013 pred_hit_curr  output  1  pred_pc matched a valid entry.

Function
REQ-014 Each entry SHALL hold: valid bit, tag = addr[31:INDEX_W+2], 32-bit target, 2-bit saturating counter.
REQ-015 Index SHALL be addr[INDEX_W+1:2]; addr[1:0] is ignored.
REQ-016 Lookup SHALL be combinational, zero latency: hit = valid AND tag match at index of pred_pc.
REQ-017 On hit: pred_hit_curr=1, pred_target_curr=stored target, pred_taken_curr=counter[1].
REQ-018 On miss: pred_hit_curr=0, pred_taken_curr=0, pred_target_curr=0.
REQ-019 Update SHALL occur at the clock edge when update_valid=1 and reset=0.
REQ-020 Update miss (invalid or tag mismatch): allocate/overwrite entry; valid=1, new tag, target=update_target, counter=2'b10 if update_taken else 2'b01.
REQ-021 Update hit: counter saturating +1 if taken (max 2'b11), -1 if not taken (min 2'b00).
REQ-022 Update hit with update_taken=1: target SHALL be overwritten with update_target; with update_taken=0, target unchanged.
REQ-023 Update hit with update_mispred=1 and update_taken=1: counter SHALL be set to 2'b11 instead of incremented; with update_mispred=1 and update_taken=0: counter set to 2'b00.
REQ-024 update_mispred SHALL have no effect on allocation (REQ-020).
REQ-025 Lookup and update of the same entry in the same cycle: lookup returns pre-update contents (unless REQ-030 applies).
REQ-026 update_valid=0: no state change.

Reset
REQ-027 While reset=1 at a rising edge: all valid bits cleared, all counters set to 2'b01, targets set to 0; concurrent updates ignored.
REQ-028 After reset all lookups miss: pred_hit_curr=0, pred_taken_curr=0, pred_target_curr=0.
REQ-029 Reset asserted mid-operation SHALL discard all trained state at that edge.

Configuration
REQ-030 Macro BPRED_BYPASS_EN: when defined, if update_valid=1, reset=0 and update_neip equals pred_pc in index and tag, outputs SHALL reflect the post-update entry contents in the same cycle; when undefined, REQ-025 applies and no bypass path exists.

Verification
REQ-031 Reset, pred_pc=16 -> hit=0, taken=0, target=0.
REQ-032 Update neip=16, target=45, taken=1, mispred=1; next cycle pred_pc=16 -> hit=1, taken=1, target=45.
REQ-033 Additionally update neip=64, target=25, taken=0, mispred=1; then pred_pc=64 -> hit=1, taken=0, target=25; pred_pc=16 still hit=1, taken=1, target=45.
REQ-034 Allocate 16 (taken) plus two taken, non-mispred updates (counter 11); one not-taken, non-mispred update -> taken=1; second -> taken=0 (counter 01).
REQ-035 Allocate 16, then update neip=80 (same index 4, different tag), target=99, taken=1 -> pred_pc=16 hit=0; pred_pc=80 hit=1, target=99.
REQ-036 Same-cycle update neip=16 (target 45, taken) with pred_pc=16 from reset: BPRED_BYPASS_EN defined -> hit=1, target=45; undefined -> hit=0.
